ib32bit_fetch_seq: RTL

Fetch sequencer for the 32-bit processor's instruction memory block. Owns the program-counter value presented to the PC register and instruction memory, issues one fetch at a time, and holds the returned instruction in a valid/ready handshake to decode. Supports branch/jump redirect, halt, and wrap-around of the AWIDTH-bit address space.

---
 rtl/ib32bit_fetch_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ib32bit_fetch_seq.sv
// Fetch sequencer: one outstanding instruction fetch, valid/ready hand-off to decode.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters.
`timescale 1ns/1ps
module ib32bit_fetch_seq #(
  parameter int unsigned        AWIDTH     = 6,
  parameter logic [AWIDTH-1:0]  RESET_ADDR = '0,
  parameter int unsigned        MEM_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_addr,
  output logic              imem_req,
  output logic [AWIDTH-1:0] pc_out,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [AWIDTH-1:0] inst_pc,
  output logic              busy,
  output logic              wrap
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, VALID} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam bit         SINGLE = (MEM_LAT == 1);

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   pc_q, pc_d;
  logic [AWIDTH-1:0]   ipc_q, ipc_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                halt_q, halt_d;
  logic                accept, halting;

  assign accept  = (state_q == VALID) && inst_ready;
  assign halting = halt_q || halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_ADDR;
      ipc_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    wrap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = RESET_ADDR;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ipc_d = pc_q;
        cnt_d = LAT_M1;
        if (SINGLE) begin
          data_d  = imem_rdata;
          state_d = VALID;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          data_d  = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (inst_ready) begin
          pc_d    = pc_q + AWIDTH'(1);
          wrap    = &pc_q;
          state_d = halting ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Redirect overrides the increment; an accepted instruction with halt pending still stops.
    if (state_q != IDLE && redirect_valid) begin
      pc_d = redirect_addr;
      wrap = 1'b0;
      if (!(accept && halting)) state_d = ISSUE;
    end
    if (state_q != IDLE && halt) halt_d = 1'b1;
    if (state_d == IDLE) halt_d = 1'b0;
  end

  assign busy       = (state_q != IDLE);
  assign imem_req   = (state_q == ISSUE);
  assign inst_valid = (state_q == VALID);
  assign pc_out     = busy ? pc_q   : '0;
  assign inst_pc    = busy ? ipc_q  : '0;
  assign inst_data  = busy ? data_q : '0;

`ifdef FETCH_PERF_EN
  logic [15:0] fcnt_q, scnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (accept && !(&fcnt_q)) fcnt_q <= fcnt_q + 16'd1;
      if (state_q == VALID && !inst_ready && !(&scnt_q)) scnt_q <= scnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fcnt_q;
  assign stall_cnt = scnt_q;
`endif

endmodule
